// File: rtl/lamp_fpu_sqrt_arbiter_if.sv
// Bundle of the request, core and response signals around the shared
// lampFPU_fractSqrt arbiter.
//   req_*  : per-requester valid/op/operand in, one-hot ready out
//   core_* : start pulses, operand and flush to the core; result/valid back
//   rsp_*  : held response with valid/ready, id, op type, result, error flag
// The slave modport is the arbiter's view. The master modport is the view
// of the surrounding logic (requesters, core, response consumer).
interface lamp_fpu_sqrt_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int F_W     = 9,
    parameter int RES_W   = 16,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    logic [NUM_REQ-1:0]     req_valid_i;
    logic [NUM_REQ-1:0]     req_inv_i;
    logic [NUM_REQ*F_W-1:0] req_f_i;
    logic [NUM_REQ-1:0]     req_ready_o;

    logic                   core_do_sqrt_o;
    logic                   core_do_inv_sqrt_o;
    logic [F_W-1:0]         core_f_o;
    logic [RES_W-1:0]       core_result_i;
    logic                   core_valid_i;
    logic                   core_flush_o;

    logic                   rsp_valid_o;
    logic                   rsp_ready_i;
    logic [ID_W-1:0]        rsp_id_o;
    logic                   rsp_inv_o;
    logic [RES_W-1:0]       rsp_result_o;
    logic                   rsp_err_o;

    modport slave (
        input  req_valid_i, req_inv_i, req_f_i,
        output req_ready_o,
        output core_do_sqrt_o, core_do_inv_sqrt_o, core_f_o, core_flush_o,
        input  core_result_i, core_valid_i,
        output rsp_valid_o, rsp_id_o, rsp_inv_o, rsp_result_o, rsp_err_o,
        input  rsp_ready_i
    );

    modport master (
        output req_valid_i, req_inv_i, req_f_i,
        input  req_ready_o,
        input  core_do_sqrt_o, core_do_inv_sqrt_o, core_f_o, core_flush_o,
        output core_result_i, core_valid_i,
        input  rsp_valid_o, rsp_id_o, rsp_inv_o, rsp_result_o, rsp_err_o,
        output rsp_ready_i
    );
endinterface

// File: rtl/lamp_fpu_sqrt_arbiter.sv
// Shares one lampFPU_fractSqrt core between NUM_REQ requesters.
// Round-robin grant, a single op in flight, result held until accepted,
// and a watchdog that aborts a hung op and flushes the core.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset
//   bus  - lamp_fpu_sqrt_arbiter_if.slave (request, core and response signals)
// Op sequence: IDLE (grant) -> START (1-cycle start pulse) -> WAIT (core
// result or timeout) -> RESP (held until rsp_ready_i) -> IDLE.
module lamp_fpu_sqrt_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int F_W     = 9,
    parameter int RES_W   = 16,
    parameter int TIMEOUT = 15,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input logic                    clk,
    input logic                    rst,
    lamp_fpu_sqrt_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef logic [ID_W:0]    scan_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam scan_t NREQ      = scan_t'(NUM_REQ);
    localparam cnt_t  CNT_LIMIT = cnt_t'(TIMEOUT);
    localparam cnt_t  CNT_PRE   = cnt_t'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  cur_id;
    logic             cur_inv;
    cnt_t             wait_cnt;

    logic             do_sqrt_q;
    logic             do_inv_q;
    logic             flush_q;
    logic [F_W-1:0]   core_f_q;

    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic             rsp_inv_q;
    logic [RES_W-1:0] rsp_result_q;
    logic             rsp_err_q;

    logic [ID_W-1:0]  grant;
    logic             grant_vld;
    scan_t            scan_idx;
    logic [F_W-1:0]   grant_f;
    logic [ID_W-1:0]  ptr_next;

    // First valid requester at or after rr_ptr, wrapping. rr_ptr + k stays
    // below 2*NUM_REQ, so a single conditional subtract is the modulo.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + scan_t'(k);
            if (scan_idx >= NREQ)
                scan_idx = scan_idx - NREQ;
            if (!grant_vld && bus.req_valid_i[scan_idx[ID_W-1:0]]) begin
                grant     = scan_idx[ID_W-1:0];
                grant_vld = 1'b1;
            end
        end
    end

    // Ready is only ever raised for the granted requester, so a handshake
    // in IDLE is exactly grant_vld.
    always_comb begin
        bus.req_ready_o = '0;
        for (int k = 0; k < NUM_REQ; k++)
            bus.req_ready_o[k] = (state == IDLE) && grant_vld && (grant == ID_W'(k));
    end

    assign grant_f  = bus.req_f_i[int'(grant)*F_W +: F_W];
    assign ptr_next = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            cur_id       <= '0;
            cur_inv      <= 1'b0;
            wait_cnt     <= '0;
            do_sqrt_q    <= 1'b0;
            do_inv_q     <= 1'b0;
            flush_q      <= 1'b0;
            core_f_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_inv_q    <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            // Start and flush are single-cycle pulses.
            do_sqrt_q <= 1'b0;
            do_inv_q  <= 1'b0;
            flush_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        cur_id    <= grant;
                        cur_inv   <= bus.req_inv_i[grant];
                        core_f_q  <= grant_f;
                        rr_ptr    <= ptr_next;
                        do_sqrt_q <= !bus.req_inv_i[grant];
                        do_inv_q  <= bus.req_inv_i[grant];
                        state     <= START;
                    end
                end
                START: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // Timeout is checked first so a core_valid_i arriving in
                    // the same cycle as the abort is dropped.
                    if (wait_cnt == CNT_LIMIT) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_id_q     <= cur_id;
                        rsp_inv_q    <= cur_inv;
                        rsp_result_q <= '0;
                        rsp_err_q    <= 1'b1;
                        state        <= RESP;
                    end else if (bus.core_valid_i) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_id_q     <= cur_id;
                        rsp_inv_q    <= cur_inv;
                        rsp_result_q <= bus.core_result_i;
                        rsp_err_q    <= 1'b0;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                        // Registered one cycle early so the flush pulse lines
                        // up with the cycle in which the counter hits TIMEOUT.
                        flush_q  <= (wait_cnt == CNT_PRE);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.core_do_sqrt_o     = do_sqrt_q;
    assign bus.core_do_inv_sqrt_o = do_inv_q;
    assign bus.core_f_o           = core_f_q;
    assign bus.core_flush_o       = flush_q;
    assign bus.rsp_valid_o        = rsp_valid_q;
    assign bus.rsp_id_o           = rsp_id_q;
    assign bus.rsp_inv_o          = rsp_inv_q;
    assign bus.rsp_result_o       = rsp_result_q;
    assign bus.rsp_err_o          = rsp_err_q;
endmodule

// File: tb/tb_lamp_fpu_sqrt_arbiter.sv
// Scoreboard bench for lamp_fpu_sqrt_arbiter. The core model answers
// 6 cycles after a start pulse with {inv, 6'b0, f}, can be told never to
// answer, and is cleared only by core_flush_o (not by rst).
module tb_lamp_fpu_sqrt_arbiter;
    localparam int NUM_REQ = 2;
    localparam int F_W     = 9;
    localparam int RES_W   = 16;
    localparam int TIMEOUT = 15;
    localparam int ID_W    = 1;

    typedef struct packed {
        logic           inv;
        logic [F_W-1:0] f;
    } op_t;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic             inv;
        logic [RES_W-1:0] result;
        logic             err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lamp_fpu_sqrt_arbiter_if #(.NUM_REQ(NUM_REQ), .F_W(F_W), .RES_W(RES_W), .ID_W(ID_W)) bus ();

    lamp_fpu_sqrt_arbiter #(
        .NUM_REQ(NUM_REQ), .F_W(F_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT), .ID_W(ID_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    op_t  rq0[$];
    op_t  rq1[$];
    int   exp_grant[$];
    rsp_t sb[$];
    bit   core_never = 1'b0;
    bit   discard = 1'b0;
    bit   hs0 = 1'b0;
    bit   hs1 = 1'b0;
    int   hs_cyc = -100;
    int   n_starts = 0;
    int   n_flush = 0;
    int   flush_cyc = -1;
    int   rsp_rise_cyc = -1;
    logic last_inv = 1'b0;
    logic [F_W-1:0] last_f = '0;
    logic prev_rsp_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic op_t mk(input logic inv, input logic [F_W-1:0] f);
        op_t o;
        o.inv = inv;
        o.f   = f;
        return o;
    endfunction

    // Core model
    logic             core_pend = 1'b0;
    int               core_cnt = 0;
    logic [RES_W-1:0] core_res = '0;
    always @(posedge clk) begin
        if (bus.core_flush_o) begin
            core_pend <= 1'b0;
        end else if ((bus.core_do_sqrt_o || bus.core_do_inv_sqrt_o) && !core_never) begin
            core_pend <= 1'b1;
            core_cnt  <= 5;
            core_res  <= {bus.core_do_inv_sqrt_o, 6'b0, bus.core_f_o};
        end else if (core_pend) begin
            if (core_cnt == 0) core_pend <= 1'b0;
            else               core_cnt  <= core_cnt - 1;
        end
    end
    assign bus.core_valid_i  = core_pend && (core_cnt == 0);
    assign bus.core_result_i = core_res;

    // Requester driver: presents the head of each queue, pops after a handshake.
    initial begin
        bus.req_valid_i = '0;
        bus.req_inv_i   = '0;
        bus.req_f_i     = '0;
        forever begin
            @(posedge clk);
            #1;
            if (hs0) begin void'(rq0.pop_front()); hs0 = 1'b0; end
            if (hs1) begin void'(rq1.pop_front()); hs1 = 1'b0; end
            bus.req_valid_i[0] = (rq0.size() > 0);
            bus.req_valid_i[1] = (rq1.size() > 0);
            if (rq0.size() > 0) begin
                bus.req_inv_i[0]       = rq0[0].inv;
                bus.req_f_i[F_W-1:0]   = rq0[0].f;
            end
            if (rq1.size() > 0) begin
                bus.req_inv_i[1]         = rq1[0].inv;
                bus.req_f_i[2*F_W-1:F_W] = rq1[0].f;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin : mon
        op_t  op;
        rsp_t e;
        if (!rst) begin
            if (bus.req_ready_o != '0)
                check("ready_onehot", $countones(bus.req_ready_o), 1);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (bus.req_valid_i[k] && bus.req_ready_o[k]) begin
                    hs_cyc = cyc;
                    if (k == 0) begin op = rq0[0]; hs0 = 1'b1; end
                    else        begin op = rq1[0]; hs1 = 1'b1; end
                    last_inv = op.inv;
                    last_f   = op.f;
                    if (exp_grant.size() == 0) check("grant_unexpected", k, 99);
                    else                       check("grant_id", k, exp_grant.pop_front());
                    if (!discard) begin
                        e.id     = ID_W'(k);
                        e.inv    = op.inv;
                        e.result = core_never ? '0 : {op.inv, 6'b0, op.f};
                        e.err    = core_never;
                        sb.push_back(e);
                    end
                end
            end
            if (bus.core_do_sqrt_o || bus.core_do_inv_sqrt_o) begin
                n_starts++;
                check("start_both", bus.core_do_sqrt_o & bus.core_do_inv_sqrt_o, 0);
                check("start_time", cyc, hs_cyc + 1);
                check("start_kind", bus.core_do_inv_sqrt_o, last_inv);
                check("start_f", bus.core_f_o, last_f);
            end
            if (bus.core_flush_o) begin
                n_flush++;
                flush_cyc = cyc;
            end
            if (bus.rsp_valid_o && !prev_rsp_valid) rsp_rise_cyc = cyc;
            prev_rsp_valid = bus.rsp_valid_o;
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp", {bus.rsp_id_o, bus.rsp_inv_o, bus.rsp_result_o, bus.rsp_err_o}, e);
                end
            end
        end else begin
            prev_rsp_valid = 1'b0;
        end
    end

    task automatic wait_idle(input string name, input int bound);
        int i;
        bit to;
        i  = 0;
        to = 1'b0;
        while (!(rq0.size() == 0 && rq1.size() == 0 && sb.size() == 0 && !bus.rsp_valid_o)) begin
            @(negedge clk);
            i++;
            if (i > bound) begin to = 1'b1; break; end
        end
        check(name, to, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp_valid(input string name, input int bound);
        int i;
        bit to;
        i  = 0;
        to = 1'b0;
        @(negedge clk);
        while (!bus.rsp_valid_o) begin
            @(negedge clk);
            i++;
            if (i > bound) begin to = 1'b1; break; end
        end
        check(name, to, 0);
    endtask

    initial begin : stim
        int s0;
        int i;
        bus.rsp_ready_i = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", {bus.req_ready_o, bus.core_do_sqrt_o, bus.core_do_inv_sqrt_o,
                          bus.core_f_o, bus.core_flush_o}, 0);
        check("rst_rsp", {bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_inv_o,
                          bus.rsp_result_o, bus.rsp_err_o}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single sqrt from requester 0: start pulse at +1, response at +8.
        exp_grant.push_back(0);
        rq0.push_back(mk(1'b0, 9'h080));
        wait_idle("t1_done", 40);
        check("t1_latency", rsp_rise_cyc - hs_cyc, 8);
        check("t1_starts", n_starts, 1);

        // Response stall: rr pointer is 1, so requester 1 wins; requester 0 waits.
        bus.rsp_ready_i = 1'b0;
        exp_grant.push_back(1);
        exp_grant.push_back(0);
        rq1.push_back(mk(1'b1, 9'h1F0));
        rq0.push_back(mk(1'b0, 9'h155));
        wait_rsp_valid("stall_rsp_seen", 30);
        s0 = n_starts;
        repeat (20) begin
            @(negedge clk);
            check("stall_rsp", {bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_inv_o,
                                bus.rsp_result_o, bus.rsp_err_o},
                  {1'b1, 1'b1, 1'b1, 16'h81F0, 1'b0});
            check("stall_ready", bus.req_ready_o, 0);
        end
        check("stall_starts", n_starts, s0);
        @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b1;
        wait_idle("stall_done", 60);

        // Hung core: flush at START+1+TIMEOUT, error response, then normal op.
        core_never = 1'b1;
        exp_grant.push_back(1);
        rq1.push_back(mk(1'b0, 9'h100));
        wait_idle("to_done", 60);
        check("to_flush_time", flush_cyc - hs_cyc, 2 + TIMEOUT);
        check("to_flush_width", n_flush, 1);
        core_never = 1'b0;
        exp_grant.push_back(0);
        rq0.push_back(mk(1'b1, 9'h0AA));
        wait_idle("to_next_done", 40);
        check("to_no_flush", n_flush, 1);

        // Reset 3 cycles after START; the op and its late core result vanish.
        discard = 1'b1;
        exp_grant.push_back(0);
        rq0.push_back(mk(1'b0, 9'h0C3));
        i = 0;
        while (rq0.size() != 0 && i < 40) begin @(posedge clk); #1; i++; end
        check("rst_op_granted", rq0.size(), 0);
        i = 0;
        while (cyc < hs_cyc + 4 && i < 10) begin @(posedge clk); #1; i++; end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ctl", {bus.req_ready_o, bus.core_do_sqrt_o, bus.core_do_inv_sqrt_o,
                             bus.core_f_o, bus.core_flush_o}, 0);
        check("midrst_rsp", {bus.rsp_valid_o, bus.rsp_id_o, bus.rsp_inv_o,
                             bus.rsp_result_o, bus.rsp_err_o}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        discard = 1'b0;
        s0 = n_starts;
        repeat (10) begin
            @(negedge clk);
            check("midrst_quiet", bus.rsp_valid_o, 0);
        end
        check("midrst_starts", n_starts, s0);
        check("midrst_sb", sb.size(), 0);
        @(posedge clk);
        #1;

        // Pointer was reset to 0: both valid -> 0 then 1.
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        rq0.push_back(mk(1'b0, 9'h011));
        rq1.push_back(mk(1'b1, 9'h1FF));
        wait_idle("ptr_done", 60);

        // Requester 1 alone with pointer at 0; pointer wraps back to 0.
        exp_grant.push_back(1);
        rq1.push_back(mk(1'b0, 9'h002));
        wait_idle("solo_done", 40);

        // Continuous contention, alternating op type: grants 0,1,0,1,...
        for (int k = 0; k < 4; k++) begin
            exp_grant.push_back(0);
            exp_grant.push_back(1);
            rq0.push_back(mk(k[0], 9'h010 + 9'(k)));
            rq1.push_back(mk(!k[0], 9'h020 + 9'(k)));
        end
        wait_idle("rr_done", 200);

        check("end_sb_empty", sb.size(), 0);
        check("end_grants_left", exp_grant.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
